// File: rtl/led_sequencer.sv
// Per-channel LED colour sequencer: synchronised, debounced push buttons and a
// shared auto-step prescaler advance colour codes with wrap or ping-pong ordering.
module led_sequencer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DIV_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          button,
    input  logic [1:0]                   mode,
    input  logic                         dir,
    input  logic [DIV_W-1:0]             period,
    output logic [CHANNELS*COLOUR_W-1:0] colour,
    output logic [CHANNELS-1:0]          wrap
);

    localparam int unsigned         CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0]    DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [COLOUR_W-1:0] C_ONE   = COLOUR_W'(1);
    localparam logic [COLOUR_W-1:0] C_TWO   = COLOUR_W'(2);
    localparam logic [COLOUR_W-1:0] C_MAX   = COLOUR_W'((1 << COLOUR_W) - 2);
    localparam logic [COLOUR_W-1:0] C_ZERO  = '0;
    localparam logic [COLOUR_W-1:0] C_ILL   = '1;

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_AUTO     = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_PINGPONG = 2'b11
    } mode_e;

    mode_e                        mode_c;
    logic [CHANNELS-1:0]          sync_q1;
    logic [CHANNELS-1:0]          sync_q2;
    logic [CHANNELS-1:0]          level_q;
    logic [CNT_W-1:0]             db_cnt_q [CHANNELS];
    logic [CHANNELS-1:0]          flip_c;
    logic [CHANNELS-1:0]          press_c;
    logic [CHANNELS-1:0]          step_c;
    logic [DIV_W-1:0]             presc_q;
    logic                         tick_c;
    logic                         pingpong_c;
    logic                         entering_c;
    logic                         pp_prev_q;
    logic [CHANNELS-1:0]          pp_up_q;
    logic [CHANNELS-1:0]          pp_up_d;
    logic [CHANNELS-1:0]          wrap_d;
    logic [CHANNELS*COLOUR_W-1:0] colour_d;
    logic [COLOUR_W-1:0]          cur_c;
    logic [COLOUR_W-1:0]          nxt_c;
    logic                         wr_c;
    logic                         up_c;

    assign mode_c     = mode_e'(mode);
    assign pingpong_c = (mode_c == MODE_PINGPONG);
    assign entering_c = pingpong_c && !pp_prev_q;

    // Two-flop synchroniser for the raw buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    // Accepted level flips on the edge where the mismatch run reaches DEBOUNCE
    always_comb begin
        flip_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            flip_c[i] = (sync_q2[i] != level_q[i]) && (db_cnt_q[i] == DB_LAST);
        end
    end

    assign press_c = flip_c & sync_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (sync_q2[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (flip_c[i]) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= sync_q2[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Shared prescaler; a shrunken period wraps on the very next edge
    assign tick_c = (period != '0) && (presc_q >= period - DIV_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (period == '0 || tick_c) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    // Step source per mode; a press coinciding with a tick is one step
    always_comb begin
        step_c = '0;
        case (mode_c)
            MODE_MANUAL:              step_c = press_c;
            MODE_AUTO, MODE_PINGPONG: step_c = press_c | {CHANNELS{tick_c}};
            MODE_HOLD:                step_c = '0;
            default:                  step_c = '0;
        endcase
    end

    // Next colour, wrap pulse and ping-pong direction per channel
    always_comb begin
        colour_d = colour;
        wrap_d   = '0;
        pp_up_d  = pp_up_q;
        cur_c    = '0;
        nxt_c    = '0;
        wr_c     = 1'b0;
        up_c     = 1'b1;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cur_c = colour[i*COLOUR_W +: COLOUR_W];
            nxt_c = cur_c;
            wr_c  = 1'b0;
            up_c  = entering_c ? dir : pp_up_q[i];
            if (step_c[i]) begin
                if (cur_c == C_ZERO || cur_c == C_ILL) begin
                    nxt_c = (pingpong_c ? up_c : dir) ? C_ONE : C_MAX;
                end else if (pingpong_c) begin
                    if (up_c && cur_c == C_MAX) begin
                        nxt_c = C_MAX - C_ONE;
                        up_c  = 1'b0;
                    end else if (!up_c && cur_c == C_ONE) begin
                        nxt_c = C_TWO;
                        up_c  = 1'b1;
                    end else begin
                        nxt_c = up_c ? cur_c + C_ONE : cur_c - C_ONE;
                    end
                end else if (dir) begin
                    wr_c  = (cur_c == C_MAX);
                    nxt_c = wr_c ? C_ONE : cur_c + C_ONE;
                end else begin
                    wr_c  = (cur_c == C_ONE);
                    nxt_c = wr_c ? C_MAX : cur_c - C_ONE;
                end
            end
            if (pingpong_c) begin
                pp_up_d[i] = up_c;
            end
            colour_d[i*COLOUR_W +: COLOUR_W] = nxt_c;
            wrap_d[i] = wr_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colour    <= '0;
            wrap      <= '0;
            pp_up_q   <= '1;
            pp_prev_q <= 1'b0;
        end else begin
            colour    <= colour_d;
            wrap      <= wrap_d;
            pp_up_q   <= pp_up_d;
            pp_prev_q <= pingpong_c;
        end
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning the number of independent LED colour channels (1..16).
REQ-002 SHALL have parameter COLOUR_W, default 3, meaning the colour code width per channel (2..8).
REQ-003 SHALL have parameter DEBOUNCE, default 4, meaning the cycles a synchronised button level must be stable before acceptance (1..255).
REQ-004 SHALL have parameter DIV_W, default 16, meaning the auto-step period counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port button, input, CHANNELS bits: raw asynchronous per-channel push buttons, active-high.
REQ-008 SHALL have port mode, input, 2 bits: 00 manual, 01 auto, 10 hold, 11 ping-pong auto.
REQ-009 SHALL have port dir, input, 1 bit: step direction in manual/auto; 1 up, 0 down.
REQ-010 SHALL have port period, input, DIV_W bits: auto-step interval in clk cycles; 0 disables auto ticks.
REQ-011 SHALL have port colour, output, CHANNELS*COLOUR_W bits: channel k at bits [k*COLOUR_W +: COLOUR_W], registered.
REQ-012 SHALL have port wrap, output, CHANNELS bits: one-cycle pulse per channel on sequence wrap, registered.

Function
REQ-013 SHALL define legal colours as 1..MAX, with MAX = 2^COLOUR_W-2; 0 and all-ones are illegal.
REQ-014 SHALL pass each button bit through a 2-flop synchroniser, then a per-channel debounce counter.
REQ-015 SHALL, in the debouncer, count while the synchronised level differs from the accepted level, clear the count on any match, and flip the accepted level when the count reaches DEBOUNCE.
REQ-016 SHALL generate a press for a channel on each 0->1 transition of that channel's accepted level; a level held high generates one press only.
REQ-017 SHALL update colour on the same edge the accepted level flips, giving DEBOUNCE+2 rising edges from the first edge at which button is sampled high.
REQ-018 SHALL implement a shared prescaler that counts 0..period-1 and emits a tick on the edge where it wraps to 0; period=0 holds the prescaler at 0 and emits no tick.
REQ-019 SHALL make a change of period take effect at the next prescaler wrap; if the counter is at or beyond the new period-1, the next edge wraps it.
REQ-020 SHALL define the step source per mode: manual steps on press; auto and ping-pong step on tick or press; hold never steps, and presses in hold are discarded.
REQ-021 SHALL apply at most one step per channel per cycle when a press and a tick coincide.
REQ-022 SHALL make an up step give c+1, with MAX going to 1 and a wrap pulse.
REQ-023 SHALL make a down step give c-1, with 1 going to MAX and a wrap pulse.
REQ-024 SHALL make a step from an illegal colour go to 1 (up) or MAX (down), with no wrap pulse.
REQ-025 SHALL, in ping-pong mode, keep a per-channel direction flag: an up step at MAX reverses to down and gives MAX-1, a down step at 1 reverses to up and gives 2; no wrap pulse. Ignores dir.
REQ-026 SHALL load the ping-pong flag from dir on entry to mode 11, evaluated on any cycle where the previous mode was not 11.
REQ-027 SHALL handle COLOUR_W=2 (MAX=2) in ping-pong mode by alternating 1<->2.
REQ-028 SHALL keep channels fully independent except for the shared prescaler, mode, dir and period.

Reset
REQ-029 SHALL, while rst=0, asynchronously force to 0: all colour channels, wrap, synchronisers, debounce counters, accepted levels and the prescaler, and set ping-pong flags to up.
REQ-030 SHALL, on reset mid-debounce, discard the partial count; after reset release a button already high is accepted DEBOUNCE+2 edges later and produces a press.
REQ-031 SHALL make the first step after reset from colour 0 follow REQ-024.

Verification (CHANNELS=4, COLOUR_W=3, DEBOUNCE=4)
REQ-032 SHALL verify reset: release rst, press ch0 once, mode 00, dir 1 -> ch0 reads 0 then 1 exactly 6 edges after the press is first sampled; others stay 0.
REQ-033 SHALL verify wrap: press ch0 six more times -> 2,3,4,5,6,1, with wrap[0] high for exactly the cycle colour goes 6->1.
REQ-034 SHALL verify bounce rejection: toggle button[1] high for 2 cycles, low, high for 3, low -> colour ch1 unchanged.
REQ-035 SHALL verify auto mode: mode 01, period 5, dir 0, ch2 at 0 -> ch2 reads 6,5,4,3,2,1,6 on consecutive ticks 5 cycles apart; press on a tick cycle gives a single step.
REQ-036 SHALL verify ping-pong: mode 11, period 3, ch3 starting at 5 with dir 1 -> 6,5,4,3,2,1,2 with no wrap pulses; then mode 10 with presses -> no change.
REQ-037 SHALL verify reset mid-operation: assert rst during auto run -> all colour/wrap read 0 asynchronously, before the next clk edge.
